pipelined_subtractor: RTL

Pipelined WIDTH-bit subtractor computing a − b − bin. Its difference bits and borrow ripple across STAGES register-separated slices, one slice per cycle. It is the subtraction counterpart of the grouped prefix adder in the ALU datapath, and serves SUB/compare/branch paths that need a registered result with status flags. It uses a valid/ready handshake on both sides, with full back-pressure.

---
 rtl/pipelined_subtractor.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/pipelined_subtractor.sv
// Pipelined subtractor: diff = a - b - bin, resolved SLICE bits per stage with
// the borrow rippling through registers. Last stage carries the result and
// status flags. A single advance signal moves or holds the whole pipe.
module pipelined_subtractor #(
   parameter int unsigned WIDTH  = 64,
   parameter int unsigned STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             overflow,
   output logic             zero,
   output logic             neg
);

   localparam int unsigned SLICE = WIDTH / STAGES;
   localparam int unsigned SW    = SLICE + 1;
   localparam int unsigned LAST  = STAGES - 1;

   // Operands are stored pre-shifted so the slice a stage resolves sits in the
   // low bits. The diff accumulator shifts in each new slice from the top, so
   // after STAGES slices it holds the full result in place.
   logic             v_q  [STAGES];
   logic [WIDTH-1:0] a_q  [STAGES];
   logic [WIDTH-1:0] b_q  [STAGES];
   logic [WIDTH-1:0] d_q  [STAGES];
   logic             br_q [STAGES];
   logic             z_q  [STAGES];
   logic             am_q [STAGES];
   logic             bm_q [STAGES];
   logic             ovf_q;

   logic             v_n  [STAGES];
   logic [WIDTH-1:0] a_n  [STAGES];
   logic [WIDTH-1:0] b_n  [STAGES];
   logic [WIDTH-1:0] d_n  [STAGES];
   logic             br_n [STAGES];
   logic             z_n  [STAGES];
   logic             am_n [STAGES];
   logic             bm_n [STAGES];
   logic             ovf_n;

   logic             adv;
   logic [SW-1:0]    slice_s;

   // One slice of subtraction; the extra top bit is the slice borrow-out.
   function automatic logic [SW-1:0] slice_sub(input logic [SLICE-1:0] x,
                                               input logic [SLICE-1:0] y,
                                               input logic             bi);
      return {1'b0, x} - {1'b0, y} - SW'(bi);
   endfunction

   // Whole pipe advances unless a held result is blocking the output.
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   // Last stage registers drive the outputs directly.
   assign out_valid = v_q[LAST];
   assign diff      = d_q[LAST];
   assign borrow    = br_q[LAST];
   assign zero      = z_q[LAST];
   assign neg       = d_q[LAST][WIDTH-1];
   assign overflow  = ovf_q;

   // Next-state of every stage: resolve one slice and pass the rest forward.
   always_comb begin
      slice_s = '0;
      ovf_n   = 1'b0;
      for (int unsigned k = 0; k < STAGES; k++) begin
         v_n[k]  = 1'b0;
         a_n[k]  = '0;
         b_n[k]  = '0;
         d_n[k]  = '0;
         br_n[k] = 1'b0;
         z_n[k]  = 1'b0;
         am_n[k] = 1'b0;
         bm_n[k] = 1'b0;
      end

      slice_s  = slice_sub(a[SLICE-1:0], b[SLICE-1:0], bin);
      v_n[0]   = in_valid;
      a_n[0]   = a >> SLICE;
      b_n[0]   = b >> SLICE;
      d_n[0]   = WIDTH'(slice_s[SLICE-1:0]) << (WIDTH - SLICE);
      br_n[0]  = slice_s[SLICE];
      z_n[0]   = (slice_s[SLICE-1:0] == '0);
      am_n[0]  = a[WIDTH-1];
      bm_n[0]  = b[WIDTH-1];

      for (int unsigned k = 1; k < STAGES; k++) begin
         slice_s = slice_sub(a_q[k-1][SLICE-1:0], b_q[k-1][SLICE-1:0], br_q[k-1]);
         v_n[k]  = v_q[k-1];
         a_n[k]  = a_q[k-1] >> SLICE;
         b_n[k]  = b_q[k-1] >> SLICE;
         d_n[k]  = (d_q[k-1] >> SLICE) | (WIDTH'(slice_s[SLICE-1:0]) << (WIDTH - SLICE));
         br_n[k] = slice_s[SLICE];
         z_n[k]  = z_q[k-1] && (slice_s[SLICE-1:0] == '0);
         am_n[k] = am_q[k-1];
         bm_n[k] = bm_q[k-1];
      end

      // Signed overflow: operand signs differ and the result sign left a's sign.
      ovf_n = (am_n[LAST] != bm_n[LAST]) && (d_n[LAST][WIDTH-1] != am_n[LAST]);
   end

   // Stage registers: clear on reset, shift together on advance, else hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            v_q[k]  <= 1'b0;
            a_q[k]  <= '0;
            b_q[k]  <= '0;
            d_q[k]  <= '0;
            br_q[k] <= 1'b0;
            z_q[k]  <= 1'b0;
            am_q[k] <= 1'b0;
            bm_q[k] <= 1'b0;
         end
         ovf_q <= 1'b0;
      end else if (adv) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            v_q[k]  <= v_n[k];
            a_q[k]  <= a_n[k];
            b_q[k]  <= b_n[k];
            d_q[k]  <= d_n[k];
            br_q[k] <= br_n[k];
            z_q[k]  <= z_n[k];
            am_q[k] <= am_n[k];
            bm_q[k] <= bm_n[k];
         end
         ovf_q <= ovf_n;
      end
   end

endmodule
